// File: rtl/scatter_trig_param.sv
// scatter_trig_param: front/back scintillator-row coincidence trigger.
// Clk CLK_PCLK_RIGHT, async rst_n; in: inp, masks, stretch_len, mode,
// prescale, enable; out: trig_out, trig_pattern, busy, cand_cnt, trig_cnt.
module scatter_trig_param #(
  parameter int N_FRONT    = 18,
  parameter int N_BACK     = 30,
  parameter int SPAN       = 3,
  parameter int STR_W      = 4,
  parameter int OUT_STAGES = 6,
  parameter int HOLDOFF    = 8,
  parameter int PRESCALE_W = 8,
  parameter int CNT_W      = 32
) (
  input  logic                      CLK_PCLK_RIGHT,
  input  logic                      rst_n,
  input  logic [N_FRONT+N_BACK-1:0] inp,
  input  logic [N_FRONT-1:0]        front_mask,
  input  logic [N_BACK-1:0]         back_mask,
  input  logic [STR_W-1:0]          stretch_len,
  input  logic [1:0]                mode,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic                      enable,
  output logic                      trig_out,
  output logic [N_FRONT-1:0]        trig_pattern,
  output logic                      busy,
  output logic [CNT_W-1:0]          cand_cnt,
  output logic [CNT_W-1:0]          trig_cnt
);

  localparam int NCH  = N_FRONT + N_BACK;
  localparam int TMAX = (OUT_STAGES > HOLDOFF) ? OUT_STAGES : HOLDOFF;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_HOLD
  } state_t;

  logic [NCH-1:0]        r_inp_q;
  logic [NCH-1:0]        r_inp_qq;
  logic [NCH-1:0]        w_rise;
  logic [NCH-1:0]        w_str;
  logic [STR_W-1:0]      w_len;
  logic [N_FRONT-1:0]    w_front;
  logic [N_BACK-1:0]     w_back;
  logic [N_FRONT-1:0]    w_grp;
  logic [N_FRONT-1:0]    w_coinc;
  logic [N_FRONT-1:0]    r_coinc;
  logic                  w_any;
  logic                  r_any_d;
  logic                  w_cand;
  logic                  w_ps_hit;
  logic                  w_fire;
  logic [PRESCALE_W-1:0] r_ps_cnt;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [TW-1:0]         r_tcnt;
  logic [TW-1:0]         w_tcnt_nxt;

  // Two-flop sampling; a rising edge is a fresh 1 after a 0.
  always_ff @(posedge CLK_PCLK_RIGHT or negedge rst_n) begin
    if (!rst_n) begin
      r_inp_q  <= '0;
      r_inp_qq <= '0;
    end else begin
      r_inp_q  <= inp;
      r_inp_qq <= r_inp_q;
    end
  end

  assign w_rise = r_inp_q & ~r_inp_qq;
  assign w_len  = (stretch_len == '0) ? STR_W'(1) : stretch_len;

  // Per-channel stretcher: reload on every edge, so retriggers extend.
  for (genvar gc = 0; gc < NCH; gc++) begin : g_str
    logic [STR_W-1:0] r_cnt;
    always_ff @(posedge CLK_PCLK_RIGHT or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_rise[gc]) begin
        r_cnt <= w_len;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
    assign w_str[gc] = (r_cnt != '0);
  end

  assign w_front = w_str[N_FRONT-1:0] & front_mask;
  assign w_back  = w_str[NCH-1:N_FRONT] & back_mask;

  // Back group of front i starts at i*N_BACK/N_FRONT, clipped at the end.
  for (genvar gi = 0; gi < N_FRONT; gi++) begin : g_grp
    localparam int BASE = (gi * N_BACK) / N_FRONT;
    logic [N_BACK-1:0] w_sel;
    for (genvar gj = 0; gj < N_BACK; gj++) begin : g_sel
      assign w_sel[gj] = (gj >= BASE) && (gj < BASE + SPAN);
    end
    assign w_grp[gi] = |(w_back & w_sel);
  end

  always_comb begin
    w_coinc = '0;
    case (mode)
      2'd0:    w_coinc = w_front & w_grp;
      2'd1:    w_coinc = w_front;
      2'd2:    w_coinc = w_grp;
      default: w_coinc = '0;
    endcase
  end

  assign w_any    = |r_coinc;
  assign w_cand   = w_any & ~r_any_d & (r_state == S_IDLE) & enable;
  assign w_ps_hit = (r_ps_cnt >= prescale);
  assign w_fire   = w_cand & w_ps_hit;

  always_ff @(posedge CLK_PCLK_RIGHT or negedge rst_n) begin
    if (!rst_n) begin
      r_coinc      <= '0;
      r_any_d      <= 1'b0;
      r_ps_cnt     <= '0;
      cand_cnt     <= '0;
      trig_cnt     <= '0;
      trig_pattern <= '0;
    end else begin
      r_coinc <= w_coinc;
      r_any_d <= w_any;
      if (w_cand) begin
        if (cand_cnt != '1) cand_cnt <= cand_cnt + 1'b1;
        r_ps_cnt <= w_ps_hit ? '0 : r_ps_cnt + 1'b1;
      end
      if (w_fire) begin
        trig_pattern <= r_coinc;
        if (trig_cnt != '1) trig_cnt <= trig_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_PCLK_RIGHT or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          w_state_nxt = S_FIRE;
          w_tcnt_nxt  = TW'(OUT_STAGES - 1);
        end
      end
      S_FIRE: begin
        if (r_tcnt != '0) begin
          w_tcnt_nxt = r_tcnt - 1'b1;
        end else if (HOLDOFF == 0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
          w_tcnt_nxt  = TW'(HOLDOFF - 1);
        end
      end
      S_HOLD: begin
        if (r_tcnt != '0) begin
          w_tcnt_nxt = r_tcnt - 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign trig_out = (r_state == S_FIRE);
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_scatter_trig_param.sv
// tb_scatter_trig_param: directed scenarios plus randomized traffic
// checked against an event-time model of the trigger.
module tb_scatter_trig_param;

  localparam int NF   = 18;
  localparam int NB   = 30;
  localparam int NCH  = NF + NB;
  localparam int SPAN = 3;
  localparam int OUT  = 6;
  localparam int HOLD = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] inp = '0;
  logic [NF-1:0]  front_mask = '1;
  logic [NB-1:0]  back_mask = '1;
  logic [3:0]     stretch_len = 4'd4;
  logic [1:0]     mode = 2'd0;
  logic [7:0]     prescale = 8'd0;
  logic           enable = 1'b1;
  logic           trig_out;
  logic [NF-1:0]  trig_pattern;
  logic           busy;
  logic [31:0]    cand_cnt;
  logic [31:0]    trig_cnt;

  int errors = 0;
  int checks = 0;

  scatter_trig_param dut (
    .CLK_PCLK_RIGHT(clk),
    .rst_n(rst_n),
    .inp(inp),
    .front_mask(front_mask),
    .back_mask(back_mask),
    .stretch_len(stretch_len),
    .mode(mode),
    .prescale(prescale),
    .enable(enable),
    .trig_out(trig_out),
    .trig_pattern(trig_pattern),
    .busy(busy),
    .cand_cnt(cand_cnt),
    .trig_cnt(trig_cnt)
  );

  always #5 clk = ~clk;

  // Event-time model: edges numbered from reset release.
  int            m_t;
  int            m_rise [NCH];
  int            m_fire;
  int            m_cand;
  int            m_trig;
  int            m_ps;
  logic [NCH-1:0] m_prev;
  logic [NCH-1:0] m_str;
  logic [NF-1:0]  m_coinc;
  logic [NF-1:0]  m_pat;
  logic           m_any;
  logic           m_any_d;

  function automatic logic m_grp(input logic [NB-1:0] b, input int i);
    int lo;
    int hi;
    logic r;
    lo = (i * NB) / NF;
    hi = lo + SPAN - 1;
    if (hi > NB - 1) hi = NB - 1;
    r = 1'b0;
    for (int j = lo; j <= hi; j++) r = r | b[j];
    return r;
  endfunction

  task automatic model_step();
    int L;
    logic cand;
    logic [NF-1:0] f;
    logic [NB-1:0] b;
    if (!rst_n) begin
      m_t = 0; m_fire = -1000; m_cand = 0; m_trig = 0; m_ps = 0;
      m_prev = '0; m_str = '0; m_coinc = '0; m_pat = '0;
      m_any = 1'b0; m_any_d = 1'b0;
      for (int j = 0; j < NCH; j++) m_rise[j] = -1000;
    end else begin
      m_t++;
      L = (stretch_len == 0) ? 1 : int'(stretch_len);
      cand = enable && m_any && !m_any_d && (m_t - 1 >= m_fire + OUT + HOLD);
      if (cand) begin
        m_cand++;
        if (m_ps >= int'(prescale)) begin
          m_ps = 0; m_fire = m_t; m_trig++; m_pat = m_coinc;
        end else begin
          m_ps++;
        end
      end
      m_any_d = m_any;
      f = m_str[NF-1:0] & front_mask;
      b = m_str[NCH-1:NF] & back_mask;
      for (int i = 0; i < NF; i++) begin
        case (mode)
          2'd0: m_coinc[i] = f[i] & m_grp(b, i);
          2'd1: m_coinc[i] = f[i];
          2'd2: m_coinc[i] = m_grp(b, i);
          default: m_coinc[i] = 1'b0;
        endcase
      end
      m_any = |m_coinc;
      for (int j = 0; j < NCH; j++) m_str[j] = (m_t <= m_rise[j] + L);
      for (int j = 0; j < NCH; j++)
        if (inp[j] && !m_prev[j]) m_rise[j] = m_t;
      m_prev = inp;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  function automatic logic [NCH-1:0] bitv(input int j);
    logic [NCH-1:0] v;
    v = '0;
    v[j] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    inp = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] md, input logic [3:0] sl,
                     input logic [7:0] ps);
    mode = md; stretch_len = sl; prescale = ps;
    front_mask = '1; back_mask = '1; enable = 1'b1;
  endtask

  task automatic pulse(input logic [NCH-1:0] v);
    inp = v;
    @(negedge clk);
    inp = '0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL rst_trig got %b want 0", trig_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (cand_cnt !== 32'd0) begin errors++; $display("FAIL rst_cand got %0d want 0", cand_cnt); end
    checks++; if (trig_cnt !== 32'd0) begin errors++; $display("FAIL rst_tcnt got %0d want 0", trig_cnt); end
    checks++; if (trig_pattern !== '0) begin errors++; $display("FAIL rst_pat got %h want 0", trig_pattern); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    logic obs [11];
    int hi;
    do_reset();
    cfg(2'd0, 4'd4, 8'd0);
    pulse(bitv(0) | bitv(18));
    obs[0] = trig_out;
    for (int j = 1; j <= 10; j++) begin @(negedge clk); obs[j] = trig_out; end
    hi = 0;
    for (int j = 0; j <= 10; j++) hi += int'(obs[j]);
    checks++; if (obs[2] !== 1'b0) begin errors++; $display("FAIL lat_k2 got %b want 0", obs[2]); end
    checks++; if (obs[3] !== 1'b1) begin errors++; $display("FAIL lat_k3 got %b want 1", obs[3]); end
    checks++; if (obs[8] !== 1'b1) begin errors++; $display("FAIL lat_k8 got %b want 1", obs[8]); end
    checks++; if (obs[9] !== 1'b0) begin errors++; $display("FAIL lat_k9 got %b want 0", obs[9]); end
    checks++; if (hi != OUT) begin errors++; $display("FAIL lat_width got %0d want %0d", hi, OUT); end
    checks++; if (trig_pattern !== 18'd1) begin errors++; $display("FAIL lat_pat got %h want 1", trig_pattern); end
    checks++; if (trig_cnt !== 32'd1) begin errors++; $display("FAIL lat_tcnt got %0d want 1", trig_cnt); end
    wait_n(20);
  endtask

  task automatic test_group_clip();
    do_reset();
    cfg(2'd0, 4'd4, 8'd0);
    pulse(bitv(17) | bitv(46));
    wait_n(20);
    checks++; if (trig_cnt !== 32'd1) begin errors++; $display("FAIL clip_hit got %0d want 1", trig_cnt); end
    checks++; if (trig_pattern !== 18'h20000) begin errors++; $display("FAIL clip_pat got %h want 20000", trig_pattern); end
    pulse(bitv(17) | bitv(44));
    wait_n(20);
    checks++; if (trig_cnt !== 32'd1) begin errors++; $display("FAIL clip_miss got %0d want 1", trig_cnt); end
    checks++; if (cand_cnt !== 32'd1) begin errors++; $display("FAIL clip_cand got %0d want 1", cand_cnt); end
  endtask

  task automatic stagger();
    pulse(bitv(0));
    @(negedge clk);
    pulse(bitv(18));
  endtask

  task automatic test_stretch();
    do_reset();
    cfg(2'd0, 4'd2, 8'd0);
    stagger();
    wait_n(20);
    checks++; if (trig_cnt !== 32'd0) begin errors++; $display("FAIL str2_tcnt got %0d want 0", trig_cnt); end
    checks++; if (cand_cnt !== 32'd0) begin errors++; $display("FAIL str2_cand got %0d want 0", cand_cnt); end
    stretch_len = 4'd4;
    stagger();
    wait_n(20);
    checks++; if (trig_cnt !== 32'd1) begin errors++; $display("FAIL str4_tcnt got %0d want 1", trig_cnt); end
  endtask

  task automatic test_prescale();
    do_reset();
    cfg(2'd0, 4'd4, 8'd2);
    for (int n = 1; n <= 9; n++) begin
      pulse(bitv(3) | bitv(24));
      wait_n(24);
      checks++;
      if (trig_cnt !== 32'(n / 3)) begin
        errors++; $display("FAIL ps_tcnt_%0d got %0d want %0d", n, trig_cnt, n / 3);
      end
    end
    checks++; if (cand_cnt !== 32'd9) begin errors++; $display("FAIL ps_cand got %0d want 9", cand_cnt); end
    prescale = 8'd0;
  endtask

  task automatic test_holdoff();
    do_reset();
    cfg(2'd0, 4'd4, 8'd0);
    pulse(bitv(0) | bitv(18));
    wait_n(7);
    pulse(bitv(0) | bitv(18));
    wait_n(30);
    checks++; if (trig_cnt !== 32'd1) begin errors++; $display("FAIL ho_near got %0d want 1", trig_cnt); end
    checks++; if (cand_cnt !== 32'd1) begin errors++; $display("FAIL ho_cand got %0d want 1", cand_cnt); end
    pulse(bitv(0) | bitv(18));
    wait_n(OUT + HOLD + 2);
    pulse(bitv(0) | bitv(18));
    wait_n(30);
    checks++; if (trig_cnt !== 32'd3) begin errors++; $display("FAIL ho_far got %0d want 3", trig_cnt); end
  endtask

  task automatic test_modes();
    do_reset();
    cfg(2'd1, 4'd4, 8'd0);
    pulse(bitv(5));
    wait_n(20);
    checks++; if (trig_pattern !== 18'h20) begin errors++; $display("FAIL m1_pat got %h want 20", trig_pattern); end
    mode = 2'd2;
    pulse(bitv(19));
    wait_n(20);
    checks++; if (trig_pattern !== 18'h3) begin errors++; $display("FAIL m2_pat got %h want 3", trig_pattern); end
    checks++; if (trig_cnt !== 32'd2) begin errors++; $display("FAIL m2_tcnt got %0d want 2", trig_cnt); end
    mode = 2'd0;
    enable = 1'b0;
    pulse(bitv(0) | bitv(18));
    wait_n(20);
    checks++; if (cand_cnt !== 32'd2) begin errors++; $display("FAIL en_cand got %0d want 2", cand_cnt); end
    enable = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    cfg(2'd0, 4'd4, 8'd0);
    pulse(bitv(0) | bitv(18));
    wait_n(4);
    checks++; if (trig_out !== 1'b1) begin errors++; $display("FAIL ar_pre got %b want 1", trig_out); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL ar_trig got %b want 0", trig_out); end
    checks++; if (trig_cnt !== 32'd0) begin errors++; $display("FAIL ar_tcnt got %0d want 0", trig_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mode = 2'd3;
    pulse(bitv(0) | bitv(18));
    wait_n(20);
    checks++; if (cand_cnt !== 32'd0) begin errors++; $display("FAIL m3_cand got %0d want 0", cand_cnt); end
    mode = 2'd0;
    front_mask = ~18'd1;
    pulse(bitv(0) | bitv(18));
    wait_n(20);
    checks++; if (trig_cnt !== 32'd0) begin errors++; $display("FAIL fmask got %0d want 0", trig_cnt); end
    front_mask = '1;
    back_mask = ~30'd1;
    pulse(bitv(0) | bitv(18));
    wait_n(20);
    checks++; if (trig_cnt !== 32'd0) begin errors++; $display("FAIL bmask got %0d want 0", trig_cnt); end
    back_mask = '1;
  endtask

  task automatic test_random();
    int dens;
    logic exp_t;
    logic exp_b;
    do_reset();
    for (int r = 0; r < 6; r++) begin
      inp = '0;
      mode = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      front_mask = NF'($urandom | $urandom);
      back_mask = NB'($urandom | $urandom);
      stretch_len = 4'($urandom_range(0, 15));
      prescale = 8'($urandom_range(0, 3));
      enable = 1'b1;
      dens = (r % 2 == 0) ? 60 : 200;
      wait_n(24);
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        exp_t = (m_t >= m_fire) && (m_t <= m_fire + OUT - 1);
        exp_b = (m_t >= m_fire) && (m_t <= m_fire + OUT + HOLD - 1);
        checks++;
        if (trig_out !== exp_t) begin
          errors++; $display("FAIL rnd_trig r%0d c%0d got %b want %b", r, c, trig_out, exp_t);
        end
        checks++;
        if (busy !== exp_b) begin
          errors++; $display("FAIL rnd_busy r%0d c%0d got %b want %b", r, c, busy, exp_b);
        end
        for (int j = 0; j < NCH; j++) inp[j] = ($urandom_range(0, dens - 1) == 0);
        enable = ($urandom_range(0, 15) != 0);
      end
      inp = '0;
      enable = 1'b1;
      wait_n(24);
      checks++;
      if (cand_cnt !== 32'(m_cand)) begin
        errors++; $display("FAIL rnd_cand r%0d got %0d want %0d", r, cand_cnt, m_cand);
      end
      checks++;
      if (trig_cnt !== 32'(m_trig)) begin
        errors++; $display("FAIL rnd_tcnt r%0d got %0d want %0d", r, trig_cnt, m_trig);
      end
      checks++;
      if (trig_pattern !== m_pat) begin
        errors++; $display("FAIL rnd_pat r%0d got %h want %h", r, trig_pattern, m_pat);
      end
    end
  endtask

  initial begin
    wait_n(2);
    test_reset();
    test_latency();
    test_group_clip();
    test_stretch();
    test_prescale();
    test_holdoff();
    test_modes();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
